// File: rtl/sram_axi_bridge_if.sv
// AXI3 master bus between the sram-like bridge and the downstream fabric.
// The bridge drives the master modport; memory-side logic uses slave.
interface sram_axi_bridge_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        output awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data sram-like ports onto one AXI3 master,
// data port first, a single transaction in flight, responses routed by ID.
module sram_axi_bridge #(
    parameter int ID_W = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    sram_axi_bridge_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        owner_q;
    logic        aw_done;
    logic        w_done;

    logic        grant;
    logic        sel_data;
    logic        sel_wr;
    logic        done;
    logic        aw_hs;
    logic        w_hs;
    logic [ID_W-1:0] owner_id;

    assign owner_id = {{(ID_W-1){1'b0}}, owner_q};
    assign sel_wr   = sel_data ? data_wr : inst_wr;
    assign aw_hs    = axi.awvalid & axi.awready;
    assign w_hs     = axi.wvalid & axi.wready;

    always_comb begin
        state_nx     = state;
        grant        = 1'b0;
        sel_data     = 1'b0;
        done         = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        unique case (state)
            IDLE: begin
                if (data_req) begin
                    grant        = 1'b1;
                    sel_data     = 1'b1;
                    data_addr_ok = 1'b1;
                end else if (inst_req) begin
                    grant        = 1'b1;
                    inst_addr_ok = 1'b1;
                end
                if (grant) begin
                    state_nx = sel_wr ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (axi.arready) begin
                    state_nx = RD_DATA;
                end
            end
            RD_DATA: begin
                // Beats for the other ID are taken off the bus and dropped.
                if (axi.rvalid && axi.rid == owner_id) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_REQ: begin
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    state_nx = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign inst_data_ok = done & ~owner_q;
    assign data_data_ok = done & owner_q;
    assign inst_rdata   = axi.rdata;
    assign data_rdata   = axi.rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            owner_q <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                addr_q  <= sel_data ? data_addr : inst_addr;
                wdata_q <= sel_data ? data_wdata : inst_wdata;
                size_q  <= sel_data ? data_size : inst_size;
                owner_q <= sel_data;
            end
            if (state == WR_REQ && state_nx == WR_REQ) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    assign axi.arid    = owner_id;
    assign axi.araddr  = addr_q;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arvalid = (state == RD_ADDR);
    assign axi.arlen   = 4'd0;
    assign axi.arburst = 2'd1;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;

    assign axi.rready  = (state == RD_DATA);

    assign axi.awid    = owner_id;
    assign axi.awaddr  = addr_q;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awvalid = (state == WR_REQ) && !aw_done;
    assign axi.awlen   = 4'd0;
    assign axi.awburst = 2'd1;
    assign axi.awlock  = 2'd0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;

    assign axi.wid     = {{(ID_W-1){1'b0}}, 1'b1};
    assign axi.wdata   = wdata_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state == WR_REQ) && !w_done;

    always_comb begin
        axi.wstrb = 4'b1111;
        unique case (size_q)
            2'd0:    axi.wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    axi.wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: axi.wstrb = 4'b1111;
        endcase
    end

    assign axi.bready  = (state == WR_RESP);

    // Response status and burst framing carry nothing for single beats.
    logic unused_in;
    assign unused_in = ^{axi.rresp, axi.rlast, axi.bresp, axi.bid};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; a negedge monitor pops the
// expected-completion queue whenever either data_ok fires.
module tb_sram_axi_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        inst_req = 0, inst_wr = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 0, data_wr = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;

    sram_axi_bridge_if #(.ID_W(4)) axi ();

    sram_axi_bridge #(.ID_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .axi          (axi)
    );

    typedef struct {
        logic        owner;
        logic        is_rd;
        logic [31:0] data;
    } sb_t;

    sb_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_owner", {30'd0, inst_data_ok, data_data_ok},
                    e.owner ? 32'd1 : 32'd2);
                if (e.is_rd)
                    chk("sb_rdata", e.owner ? data_rdata : inst_rdata, e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic addr_ok_of(input bit port);
        return port ? data_addr_ok : inst_addr_ok;
    endfunction

    function automatic logic data_ok_of(input bit port);
        return port ? data_data_ok : inst_data_ok;
    endfunction

    task automatic req(input bit port, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            data_req = 1; data_wr = wr; data_size = size;
            data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1; inst_wr = wr; inst_size = size;
            inst_addr = addr; inst_wdata = wdata;
        end
    endtask

    task automatic unreq(input bit port);
        if (port) data_req = 0;
        else      inst_req = 0;
    endtask

    task automatic read_txn(input bit port, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] data);
        req(port, 0, size, addr, 32'd0);
        #1;
        chk("rd_addr_ok", addr_ok_of(port), 1);
        sb.push_back('{port, 1'b1, data});
        tick;
        unreq(port);
        #1;
        chk("arvalid", axi.arvalid, 1);
        chk("araddr", axi.araddr, addr);
        chk("arid", axi.arid, port);
        chk("arsize", axi.arsize, {1'b0, size});
        axi.arready = 1;
        tick;
        axi.arready = 0;
        #1;
        chk("rready", {axi.arvalid, axi.rready}, 2'b01);
        axi.rvalid = 1; axi.rid = port; axi.rdata = data;
        #1;
        chk("rd_data_ok", data_ok_of(port), 1);
        tick;
        axi.rvalid = 0;
        #1;
        chk("rd_ok_pulse", {inst_data_ok, data_data_ok, axi.rready}, 0);
    endtask

    task automatic write_txn(input bit port, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb);
        req(port, 1, size, addr, wdata);
        #1;
        chk("wr_addr_ok", addr_ok_of(port), 1);
        sb.push_back('{port, 1'b0, 32'd0});
        tick;
        unreq(port);
        #1;
        chk("aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        chk("awaddr", axi.awaddr, addr);
        chk("awid", axi.awid, port);
        chk("awsize", axi.awsize, {1'b0, size});
        chk("wdata", axi.wdata, wdata);
        chk("wstrb", axi.wstrb, strb);
        chk("wid_wlast", {axi.wid, axi.wlast}, 5'b00011);
        axi.awready = 1; axi.wready = 1;
        tick;
        axi.awready = 0; axi.wready = 0;
        #1;
        chk("wr_resp_wait", {axi.awvalid, axi.wvalid, axi.bready,
                             data_ok_of(port)}, 4'b0010);
        tick;
        chk("wr_no_early_ok", data_ok_of(port), 0);
        axi.bvalid = 1;
        #1;
        chk("wr_data_ok", data_ok_of(port), 1);
        tick;
        axi.bvalid = 0;
    endtask

    initial begin
        axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0;
        axi.rresp = 0; axi.rlast = 1; axi.awready = 0; axi.wready = 0;
        axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;

        tick;
        tick;
        chk("rst_valids", {axi.arvalid, axi.rready, axi.awvalid,
                           axi.wvalid, axi.bready}, 0);
        chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok,
                        data_data_ok}, 0);
        chk("rst_latched", axi.araddr, 0);
        chk("ar_consts", {axi.arlen, axi.arburst, axi.arlock, axi.arcache,
                          axi.arprot}, {4'd0, 2'd1, 2'd0, 4'd0, 3'd0});
        chk("aw_consts", {axi.awlen, axi.awburst, axi.awlock, axi.awcache,
                          axi.awprot}, {4'd0, 2'd1, 2'd0, 4'd0, 3'd0});
        rst = 0;
        tick;

        read_txn(0, 2'd2, 32'hBFC0_0380, 32'h3C08_BFC0);
        write_txn(1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 4'b1000);
        write_txn(0, 2'd2, 32'h0000_0010, 32'h1122_3344, 4'b1111);
        write_txn(1, 2'd1, 32'h8000_0000, 32'h5566_7788, 4'b0011);
        write_txn(1, 2'd0, 32'h8000_0001, 32'h0000_00CD, 4'b0010);

        // half write, awready late while wready is immediate
        req(1, 1, 2'd1, 32'h8000_0002, 32'hBEEF_0000);
        #1;
        chk("hw_addr_ok", data_addr_ok, 1);
        sb.push_back('{1'b1, 1'b0, 32'd0});
        tick;
        unreq(1);
        #1;
        chk("hw_wstrb", axi.wstrb, 4'b1100);
        axi.wready = 1;
        tick;
        axi.wready = 0;
        #1;
        chk("hw_w_dropped", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
        tick;
        chk("hw_aw_held2", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
        tick;
        chk("hw_aw_held3", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
        axi.awready = 1;
        tick;
        axi.awready = 0;
        #1;
        chk("hw_resp", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
        axi.bvalid = 1;
        #1;
        chk("hw_data_ok", data_data_ok, 1);
        tick;
        axi.bvalid = 0;

        // both ports at once: data first, inst on the next IDLE cycle
        req(1, 0, 2'd2, 32'h8000_1000, 32'd0);
        req(0, 0, 2'd2, 32'hBFC0_0000, 32'd0);
        #1;
        chk("arb_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
        sb.push_back('{1'b1, 1'b1, 32'hA5A5_0001});
        tick;
        unreq(1);
        #1;
        chk("arb_arid1", axi.arid, 1);
        chk("arb_inst_wait", inst_addr_ok, 0);
        axi.arready = 1;
        tick;
        axi.arready = 0;
        axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'hA5A5_0001;
        #1;
        chk("arb_data_ok", {data_data_ok, inst_addr_ok}, 2'b10);
        tick;
        axi.rvalid = 0;
        #1;
        chk("arb_inst_grant", inst_addr_ok, 1);
        sb.push_back('{1'b0, 1'b1, 32'h0BAD_F00D});
        tick;
        unreq(0);
        #1;
        chk("arb_arid0", {axi.arvalid, axi.arid}, 5'b10000);
        chk("arb_araddr0", axi.araddr, 32'hBFC0_0000);
        axi.arready = 1;
        tick;
        axi.arready = 0;
        axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h0BAD_F00D;
        #1;
        chk("arb_inst_ok", inst_data_ok, 1);
        tick;
        axi.rvalid = 0;

        // reset while waiting in RD_DATA
        req(1, 0, 2'd2, 32'h8000_2000, 32'd0);
        #1;
        chk("rst_txn_grant", data_addr_ok, 1);
        tick;
        unreq(1);
        axi.arready = 1;
        tick;
        axi.arready = 0;
        repeat (5) tick;
        chk("rst_txn_waiting", axi.rready, 1);
        rst = 1;
        tick;
        chk("rst_mid_valids", {axi.arvalid, axi.rready, axi.awvalid,
                               axi.wvalid, axi.bready}, 0);
        chk("rst_mid_oks", {inst_data_ok, data_data_ok}, 0);
        rst = 0;
        tick;
        read_txn(0, 2'd2, 32'hBFC0_0010, 32'h2402_0001);

        // stray beat for inst while data owns the bus
        req(1, 0, 2'd2, 32'h8000_3000, 32'd0);
        #1;
        sb.push_back('{1'b1, 1'b1, 32'hCAFE_F00D});
        tick;
        unreq(1);
        axi.arready = 1;
        tick;
        axi.arready = 0;
        axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hDEAD_BEEF;
        #1;
        chk("stray_dropped", {inst_data_ok, data_data_ok, axi.rready}, 3'b001);
        tick;
        axi.rid = 1; axi.rdata = 32'hCAFE_F00D;
        #1;
        chk("stray_then_ok", data_data_ok, 1);
        tick;
        axi.rvalid = 0;
        tick;

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's two sram-like ports (inst, data).
- Converts them into a single AXI3 master port.
- Arbitrates between the two ports, holds one transaction in flight, generates write strobes and routes responses back by ID.
- Everything after the core (crossbar, memory controller) sees only AXI.

Parameters:
- ID_W, 4, AXI ID width; inst uses ID 0, data uses ID 1.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- inst_req/inst_wr  in  1/1  inst request, write flag.
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_addr/inst_wdata  in  32/32  address, write data.
- inst_rdata  out  32  read data, valid with inst_data_ok.
- inst_addr_ok/inst_data_ok  out  1/1  request accepted / transaction complete pulse.
- data_req/data_wr/data_size/data_addr/data_wdata/data_rdata/data_addr_ok/data_data_ok: same as inst_*, for data.
- arid  out  ID_W  read address channel (group).
- araddr  out  32  read address channel (group).
- arsize  out  3  read address channel (group).
- arvalid  out  1  read address channel (group).
- arready  in  1  read address channel (group).
- arlen/arburst/arlock/arcache/arprot  out  4/2/2/4/3  constants 0/1/0/0/0.
- rid  in  ID_W  read data channel (group).
- rdata  in  32  read data channel (group).
- rresp  in  2  read data channel (group).
- rlast  in  1  read data channel (group).
- rvalid  in  1  read data channel (group).
- rready  out  1  read data channel (group).
- awid  out  ID_W  write address channel (group).
- awaddr  out  32  write address channel (group).
- awsize  out  3  write address channel (group).
- awvalid  out  1  write address channel (group).
- awready  in  1  write address channel (group).
- awlen/awburst/awlock/awcache/awprot  out  4/2/2/4/3  constants 0/1/0/0/0.
- wid  out  ID_W  write data channel, always 1.
- wdata  out  32  write data channel.
- wstrb  out  4  write data channel.
- wlast  out  1  write data channel, constant 1.
- wvalid  out  1  write data channel.
- wready  in  1  write data channel.
- bid  in  ID_W  write response channel (group).
- bresp  in  2  write response channel (group).
- bvalid  in  1  write response channel (group).
- bready  out  1  write response channel (group).

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset → IDLE.
- Reset values: all *valid/*ready, addr_ok/data_ok outputs 0; latched addr/wdata/size/id 0.
- IDLE arbitration: data_req has priority over inst_req.
  - Winner's *_addr_ok=1 combinationally in that same cycle; the other port's addr_ok=0.
  - On the clock edge: latch addr, size, wdata, wr, owner (0=inst, 1=data).
  - Next state is RD_ADDR if wr=0, else WR_REQ.
- addr_ok is only ever asserted in IDLE, so the bridge holds at most one outstanding transaction.
- RD_ADDR:
  - arvalid=1; araddr=latched addr; arsize={1'b0,size}; arid=owner.
  - On arvalid&arready → RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid&rready&rid==owner: owner's *_data_ok=1 and *_rdata=rdata combinationally, same cycle; → IDLE.
  - rresp is ignored.
  - Beats with a mismatched rid are accepted and dropped.
- WR_REQ:
  - awvalid and wvalid both asserted on entry.
  - Each deasserts after its own handshake; handshakes may occur in either order or in the same cycle.
  - When both are done → WR_RESP.
  - awaddr=latched addr; awsize={1'b0,size}; awid=owner; wdata=latched wdata.
- wstrb:
  - size 0: 4'b0001<<addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2 or 3: 4'b1111.
- WR_RESP: bready=1. On bvalid → owner's *_data_ok=1 for one cycle, → IDLE. bresp is ignored.
- No new request is accepted in the cycle data_ok fires; it can be accepted in the following IDLE cycle.
  - Back-to-back throughput: read ≥3 cycles, write ≥3 cycles.
- Requester holds req/addr/wdata stable until addr_ok. The bridge samples them only in the addr_ok cycle.
- Both ports requesting in IDLE: data served first. inst_req stays high and is granted in the next IDLE cycle, so there is no starvation of data.
- rst asserted mid-transaction: FSM → IDLE, all valids drop next edge. The outstanding AXI transaction is abandoned; downstream is reset together.
- No combinational path from core inputs to AXI outputs. AXI outputs come from registered state and latched fields only.

Test Plan:
- inst read addr 0xBFC00380, size 2 → inst_addr_ok in cycle 0; araddr=0xBFC00380, arid=0, arsize=2; slave returns 0x3C08BFC0 with rid=0 → inst_data_ok pulse 1 cycle with inst_rdata=0x3C08BFC0.
- data byte write addr 0x80000003, wdata 0x000000AB → awaddr=0x80000003, wstrb=4'b1000, wid=1; data_data_ok pulses only after bvalid.
- Half write addr 0x80000002 → wstrb=4'b1100; awready delayed 3 cycles while wready is immediate → wvalid drops after 1 cycle, awvalid held 3 cycles; WR_RESP entered only after both handshakes.
- inst_req and data_req asserted together → data_addr_ok first, inst_addr_ok=0; after data_data_ok, inst granted on next IDLE cycle; arid sequence 1 then 0.
- Read with rvalid delayed 5 cycles, then rst pulsed during RD_DATA → all valid/ready outputs 0, no data_ok emitted; next request proceeds normally from IDLE.
- Stray beat with rid=0 arriving while owner=1 → beat dropped, no inst_data_ok; correct rid=1 beat then completes.
